// File: rtl/data_mem_pkg.sv
// Shared CPU constants: data memory state encoding and defaults, plus
// reservation-station sizing used by the issue logic.
package data_mem_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned MEM_AW_DEF  = 8;
    localparam int unsigned MEM_LAT_DEF = 3;
    localparam int unsigned MEM_CNT_W   = 4;
    localparam int unsigned STATE_W     = 3;

    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD_WAIT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_STORE_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ST_LOAD_RESP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_STORE_RESP = 3'd4;

    // Reservation-station sizing shared with the load/store issue stage.
    localparam int unsigned RS_ENTRIES = 4;
    localparam int unsigned RS_TAG_W   = 2;

    // Latency counter preload: LAT-1 remaining wait cycles after acceptance.
    function automatic logic [MEM_CNT_W-1:0] lat_preload(input int unsigned lat);
        return MEM_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port word array: synchronous write, registered read that returns
// zero in any cycle without a read, so the read register can drive a bus.
module mem_array_1rw
    import data_mem_pkg::*;
#(
    parameter int unsigned AW = MEM_AW_DEF,
    parameter int unsigned DW = WORD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/data_mem.sv
// Fixed-latency data memory: one load or store outstanding, load priority,
// single-cycle response pulses on memReady/storeDone.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned AW  = MEM_AW_DEF,
    parameter int unsigned LAT = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        loadMem,
    input  logic [15:0] memAddr,
    output logic        memReady,
    output logic [15:0] memOut,
    input  logic        storeMem,
    input  logic [15:0] storeAddr,
    input  logic [15:0] storeData,
    output logic        storeDone,
    output logic        busy
);

    localparam int unsigned CW       = MEM_CNT_W;
    localparam logic [CW-1:0] CNT_INIT = lat_preload(LAT);
    localparam bit LAT_ONE           = (LAT == 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [AW-1:0]      addr_q;
    logic [AW-1:0]      addr_nxt;
    logic [WORD_W-1:0]  data_q;
    logic [WORD_W-1:0]  data_nxt;
    logic               ready_nxt;
    logic               done_nxt;
    logic               busy_nxt;
    logic               arr_en_c;
    logic               arr_we_c;

    // Next-state, capture and response decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        data_nxt  = data_q;

        case (state)
            ST_IDLE: begin
                if (loadMem) begin
                    addr_nxt  = memAddr[AW-1:0];
                    cnt_nxt   = CNT_INIT;
                    state_nxt = LAT_ONE ? ST_LOAD_RESP : ST_LOAD_WAIT;
                end else if (storeMem) begin
                    addr_nxt  = storeAddr[AW-1:0];
                    data_nxt  = storeData;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = LAT_ONE ? ST_STORE_RESP : ST_STORE_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_LOAD_RESP;
                end
            end
            ST_STORE_WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_STORE_RESP;
                end
            end
            ST_LOAD_RESP: begin
                state_nxt = ST_IDLE;
            end
            ST_STORE_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        ready_nxt = (state_nxt == ST_LOAD_RESP);
        done_nxt  = (state_nxt == ST_STORE_RESP);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    // The array is touched only on the edge entering a RESP state; a reset
    // in flight must not let that edge write.
    always_comb begin
        arr_en_c = rst_n && (ready_nxt || done_nxt);
        arr_we_c = rst_n && done_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            memReady  <= 1'b0;
            storeDone <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            memReady  <= ready_nxt;
            storeDone <= done_nxt;
            busy      <= busy_nxt;
        end
    end

    // memOut is the array read register, which is zero outside a load response.
    mem_array_1rw #(
        .AW (AW),
        .DW (WORD_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arr_en_c),
        .we    (arr_we_c),
        .addr  (addr_nxt),
        .wdata (data_nxt),
        .rdata (memOut)
    );

    if (AW < 16) begin : g_hi_addr
        logic unused_hi_addr;
        assign unused_hi_addr = ^{memAddr[15:AW], storeAddr[15:AW]};
    end

endmodule

// File: tb/tb_data_mem.sv
// Random and directed checks of data_mem (LAT=3 and LAT=1 instances)
// against a transaction-level reference memory model.
module tb_data_mem;

    localparam int unsigned AW = 8;
    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ld [2];
    logic        st [2];
    logic [15:0] ma [2];
    logic [15:0] sa [2];
    logic [15:0] sd [2];
    logic        rdy [2];
    logic        sdone [2];
    logic        bsy [2];
    logic [15:0] out [2];

    int checks = 0;
    int passes = 0;

    data_mem #(.AW(AW), .LAT(LAT0)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .loadMem(ld[0]), .memAddr(ma[0]), .memReady(rdy[0]), .memOut(out[0]),
        .storeMem(st[0]), .storeAddr(sa[0]), .storeData(sd[0]),
        .storeDone(sdone[0]), .busy(bsy[0])
    );

    data_mem #(.AW(AW), .LAT(LAT1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .loadMem(ld[1]), .memAddr(ma[1]), .memReady(rdy[1]), .memOut(out[1]),
        .storeMem(st[1]), .storeAddr(sa[1]), .storeData(sd[1]),
        .storeDone(sdone[1]), .busy(bsy[1])
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // Reference model: one access per device; a request seen at an edge while
    // idle completes LAT cycles later; the device is free again LAT+1 edges on.
    int          cyc = 0;
    int          pend [2];      // 0 none, 1 load, 2 store
    int          done_at [2];
    logic [AW-1:0] p_addr [2];
    logic [15:0] p_data [2];
    logic [15:0] ref_mem [2][256];
    int          acc_n [2];
    int          acc_cyc [2];
    int          acc_kind [2];
    int          sdone_cnt [2];

    task automatic model_edge(input int d);
        bit idle;
        idle = (pend[d] == 0) || (cyc >= done_at[d] + 2);
        if (idle && (ld[d] || st[d])) begin
            pend[d]    = ld[d] ? 1 : 2;
            p_addr[d]  = ld[d] ? ma[d][AW-1:0] : sa[d][AW-1:0];
            p_data[d]  = ld[d] ? ref_mem[d][p_addr[d]] : sd[d];
            done_at[d] = cyc + lat_of(d) - 1;
            acc_n[d]++;
            acc_cyc[d]  = cyc;
            acc_kind[d] = pend[d];
        end
        if (pend[d] == 2 && cyc == done_at[d]) ref_mem[d][p_addr[d]] = p_data[d];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) pend[d] = 0;
        end else begin
            cyc = cyc + 1;
            for (int d = 0; d < 2; d++) model_edge(d);
        end
    end

    // Per-cycle comparison of all outputs of both instances.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        e_r, e_s, e_b;
            logic [15:0] e_o;
            e_r = (pend[d] == 1) && (cyc == done_at[d]);
            e_s = (pend[d] == 2) && (cyc == done_at[d]);
            e_b = (pend[d] != 0) && (cyc <= done_at[d]);
            e_o = e_r ? p_data[d] : 16'h0000;
            chk($sformatf("u%0d.memReady", d), 32'(rdy[d]), 32'(e_r));
            chk($sformatf("u%0d.storeDone", d), 32'(sdone[d]), 32'(e_s));
            chk($sformatf("u%0d.busy", d), 32'(bsy[d]), 32'(e_b));
            chk($sformatf("u%0d.memOut", d), 32'(out[d]), 32'(e_o));
            if (sdone[d] === 1'b1) sdone_cnt[d]++;
        end
    end

    task automatic wait_acc(input int d, input int n0, output int waited);
        waited = 0;
        while (acc_n[d] == n0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("u%0d accept", d), 32'(acc_n[d] != n0), 32'd1);
    endtask

    task automatic req(input int d, input bit is_load, input logic [15:0] a,
                       input logic [15:0] dat, output int waited);
        int n0;
        n0 = acc_n[d];
        if (is_load) begin
            ld[d] = 1'b1; ma[d] = a;
        end else begin
            st[d] = 1'b1; sa[d] = a; sd[d] = dat;
        end
        wait_acc(d, n0, waited);
        ld[d] = 1'b0;
        st[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, input bit is_load, output int lat, output logic [15:0] data);
        bit seen;
        seen = 0; lat = -1; data = 16'h0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            if ((is_load ? rdy[d] : sdone[d]) === 1'b1) begin
                seen = 1;
                lat  = cyc - acc_cyc[d] + 1;
                data = out[d];
            end
        end
        chk($sformatf("u%0d response seen", d), 32'(seen), 32'd1);
    endtask

    task automatic do_store(input int d, input logic [15:0] a, input logic [15:0] dat);
        int w, lat;
        logic [15:0] v;
        req(d, 1'b0, a, dat, w);
        wait_resp(d, 1'b0, lat, v);
        chk($sformatf("u%0d store latency", d), 32'(lat), 32'(lat_of(d)));
    endtask

    task automatic do_load(input int d, input logic [15:0] a, output logic [15:0] v, output int lat);
        int w;
        req(d, 1'b1, a, 16'h0, w);
        wait_resp(d, 1'b1, lat, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, r, n0, s0;
        logic [15:0] v;
        for (int d = 0; d < 2; d++) begin
            ld[d] = 0; st[d] = 0; ma[d] = 0; sa[d] = 0; sd[d] = 0;
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d reset memReady", d), 32'(rdy[d]), 32'd0);
            chk($sformatf("u%0d reset storeDone", d), 32'(sdone[d]), 32'd0);
            chk($sformatf("u%0d reset busy", d), 32'(bsy[d]), 32'd0);
            chk($sformatf("u%0d reset memOut", d), 32'(out[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load at LAT=3; first request right after reset release.
        req(0, 1'b0, 16'h0005, 16'hBEEF, w);
        chk("first accept after reset", 32'(w), 32'd1);
        wait_resp(0, 1'b0, lat, v);
        chk("store 0x05 latency", 32'(lat), 32'd3);
        do_load(0, 16'h0005, v, lat);
        chk("load 0x05 latency", 32'(lat), 32'd3);
        chk("load 0x05 data", 32'(v), 32'h0000BEEF);

        // Simultaneous load and store: load first, store right after.
        n0 = acc_n[0];
        ld[0] = 1'b1; ma[0] = 16'h0005;
        st[0] = 1'b1; sa[0] = 16'h0006; sd[0] = 16'h1234;
        wait_acc(0, n0, w);
        ld[0] = 1'b0;
        chk("collision winner is load", 32'(acc_kind[0]), 32'd1);
        wait_resp(0, 1'b1, lat, v);
        r = cyc;
        chk("collision load data", 32'(v), 32'h0000BEEF);
        n0 = acc_n[0];
        wait_acc(0, n0, w);
        st[0] = 1'b0;
        chk("held store accepted", 32'(acc_kind[0]), 32'd2);
        chk("held store accept gap", 32'(acc_cyc[0] - r), 32'd2);
        wait_resp(0, 1'b0, lat, v);
        do_load(0, 16'h0006, v, lat);
        chk("load 0x06 data", 32'(v), 32'h00001234);

        // Address aliasing.
        do_store(0, 16'h0107, 16'h00AA);
        do_load(0, 16'h0007, v, lat);
        chk("alias 0x0107->0x07 data", 32'(v), 32'h000000AA);

        // Reset during a store aborts it.
        do_store(0, 16'h0010, 16'hBEEF);
        req(0, 1'b0, 16'h0010, 16'h5555, w);
        @(negedge clk);
        s0 = sdone_cnt[0];
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("aborted store no storeDone", 32'(sdone_cnt[0] - s0), 32'd0);
        do_load(0, 16'h0010, v, lat);
        chk("aborted store keeps 0x10", 32'(v), 32'h0000BEEF);

        // Fill both arrays so the random phase reads defined data.
        fork
            begin
                for (int a = 0; a < 256; a++) do_store(0, 16'(a), 16'($urandom));
            end
            begin
                for (int a = 0; a < 256; a++) do_store(1, 16'(a), 16'($urandom));
            end
        join

        // LAT=1 directed.
        do_store(1, 16'h0044, 16'hCAFE);
        do_load(1, 16'h0144, v, lat);
        chk("lat1 load latency", 32'(lat), 32'd1);
        chk("lat1 alias data", 32'(v), 32'h0000CAFE);

        // Random traffic: mixed on LAT=3, mostly loads on LAT=1.
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    ld[0] = ($urandom_range(0, 3) == 0);
                    st[0] = ($urandom_range(0, 2) == 0);
                    ma[0] = 16'($urandom);
                    sa[0] = 16'($urandom);
                    sd[0] = 16'($urandom);
                    @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 1500; i++) begin
                    ld[1] = ($urandom_range(0, 1) == 0);
                    st[1] = ($urandom_range(0, 7) == 0);
                    ma[1] = 16'($urandom);
                    sa[1] = 16'($urandom);
                    sd[1] = 16'($urandom);
                    @(negedge clk);
                end
            end
        join
        for (int d = 0; d < 2; d++) begin
            ld[d] = 0; st[d] = 0;
        end
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
